// File: rtl/deskew_pkg.sv
// Shared widths and lane type for the deskew collector and its FIFO.
package deskew_pkg;

  localparam int unsigned DW_DEF    = 64;
  localparam int unsigned DN_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 16;

  function automatic int unsigned sdw_of(input int unsigned dw, input int unsigned dn);
    return dw / dn;
  endfunction

  function automatic int unsigned ptr_w_of(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w_of(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned inf_w_of(input int unsigned dn);
    return $clog2(dn + 1);
  endfunction

  localparam int unsigned SDW   = sdw_of(DW_DEF, DN_DEF);
  localparam int unsigned PTR_W = ptr_w_of(DEPTH_DEF);
  localparam int unsigned CNT_W = cnt_w_of(DEPTH_DEF);
  localparam int unsigned INF_W = inf_w_of(DN_DEF);

  typedef logic [SDW-1:0] lane_t;

endpackage

// File: rtl/deskew_collector_sync_fifo.sv
// Register-based synchronous FIFO; head word is read straight from storage at rd_ptr.
module sync_fifo
  import deskew_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DW-1:0]                 din,
  output logic [DW-1:0]                 dout,
  output logic [cnt_w_of(DEPTH)-1:0]    count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PW = ptr_w_of(DEPTH);
  localparam int unsigned CW = cnt_w_of(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/deskew_collector.sv
// Realigns skewed PE-array lanes into full words, buffers them and issues launch credit.
// Optional DESKEW_LANE_CHECK_EN adds a sticky lane_err for inconsistent lane valids.
module deskew_collector
  import deskew_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned DN    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] xi,
  input  logic [DN-1:0] vi,
  output logic          accept_ok,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ovf,
  input  logic          ovf_clr
`ifdef DESKEW_LANE_CHECK_EN
  ,
  output logic          lane_err
`endif
);

  localparam int unsigned LW = sdw_of(DW, DN);
  localparam int unsigned CW = cnt_w_of(DEPTH);
  localparam int unsigned IW = inf_w_of(DN);
  localparam int unsigned SW = CW + 1;
`ifdef DESKEW_LANE_CHECK_EN
  localparam int unsigned VN = DN;
`else
  localparam int unsigned VN = 1;
  logic unused_vi;
  assign unused_vi = ^vi[DN-1:1];
`endif

  logic [DW-1:0] aw;
  logic [VN-1:0] avl;
  logic          av;

  // Lane i sits behind DN-1-i data stages; the last lane needs none.
  for (genvar i = 0; i < int'(DN); i++) begin : g_lane
    localparam int unsigned L = DN - 1 - i;
    if (L == 0) begin : g_comb
      assign aw[LW*i +: LW] = xi[LW*i +: LW];
    end else begin : g_dly
      logic [LW-1:0] d [L];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < int'(L); k++) d[k] <= '0;
        end else begin
          d[0] <= xi[LW*i +: LW];
          for (int k = 1; k < int'(L); k++) d[k] <= d[k-1];
        end
      end
      assign aw[LW*i +: LW] = d[L-1];
    end
  end

  // Valid chains: lane 0 always, the rest only when lane checking is built in.
  for (genvar i = 0; i < int'(VN); i++) begin : g_vld
    localparam int unsigned L = DN - 1 - i;
    if (L == 0) begin : g_comb
      assign avl[i] = vi[i];
    end else begin : g_dly
      logic [L-1:0] v;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= '0;
        end else begin
          v[0] <= vi[i];
          for (int k = 1; k < int'(L); k++) v[k] <= v[k-1];
        end
      end
      assign avl[i] = v[L-1];
    end
  end

  assign av = avl[0];

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [IW-1:0] inflight;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = av && (!full || pop);
  assign drop      = av && full && !pop;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (aw),
    .dout  (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Words launched but not yet aligned; together with count this gates new launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (vi[0] && !av) begin
      inflight <= inflight + IW'(1);
    end else if (!vi[0] && av) begin
      inflight <= inflight - IW'(1);
    end
  end

  assign accept_ok = (SW'(count) + SW'(inflight)) < SW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef DESKEW_LANE_CHECK_EN
  logic skew_bad;
  assign skew_bad = (avl != '0) && (avl != '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           lane_err <= 1'b0;
    else if (skew_bad) lane_err <= 1'b1;
    else if (ovf_clr)  lane_err <= 1'b0;
  end
`endif

endmodule
